// File: rtl/sync_barrier_sched_if.sv
// rtl/sync_barrier_sched_if.sv - configuration, node and collector signals of the barrier scheduler
// slave is the scheduler side; master is the side driving configuration, node requests and collector responses.
interface sync_barrier_sched_if #(
  parameter int NODE_NUM = 12,
  parameter int ID_W     = 4
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [NODE_NUM-1:0] cfg_target;
  logic [NODE_NUM-1:0] node_req;
  logic [NODE_NUM-1:0] node_release;
  logic                sync_init;
  logic [NODE_NUM-1:0] sync_target;
  logic                sync_req;
  logic [ID_W-1:0]     sync_node_id;
  logic                sync_gnt;
  logic                sync_hit;
  logic                busy;
  logic                timeout_err;

  modport slave (
    input  cfg_valid, cfg_target, node_req, sync_gnt, sync_hit,
    output cfg_ready, node_release, sync_init, sync_target, sync_req,
           sync_node_id, busy, timeout_err
  );

  modport master (
    output cfg_valid, cfg_target, node_req, sync_gnt, sync_hit,
    input  cfg_ready, node_release, sync_init, sync_target, sync_req,
           sync_node_id, busy, timeout_err
  );
endinterface

// File: rtl/sync_barrier_sched.sv
// rtl/sync_barrier_sched.sv - round-robin barrier scheduler in front of the dnoc sync collector
// Optional COLLECT timeout is built only when SYNC_TIMEOUT_EN is defined.
module sync_barrier_sched #(
  parameter int NODE_NUM    = 12,
  parameter int ID_W        = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  sync_barrier_sched_if.slave  bus
);

  if ((2 ** ID_W) < NODE_NUM) begin : g_bad_id_w
    $error("ID_W too narrow for NODE_NUM");
  end
  if ((TIMEOUT_CYC < 1) || (TIMEOUT_CYC > 65535)) begin : g_bad_timeout
    $error("TIMEOUT_CYC out of range");
  end

  typedef enum logic [1:0] {IDLE, INIT, COLLECT, RELEASE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [NODE_NUM-1:0] target_reg;
  logic [NODE_NUM-1:0] sent;
  logic [NODE_NUM-1:0] pending;
  logic [NODE_NUM-1:0] release_q;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     ptr_nxt;
  logic [ID_W-1:0]     last_id;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_found;
  logic                accept;
  logic                issue;
  logic                timeout_fire;
  logic                to_release;
  logic                cfg_ready_c;
  logic                busy_c;
  logic                sync_init_c;
  logic                sync_req_c;
  logic [ID_W-1:0]     node_id_c;

  assign accept  = (state == IDLE) && bus.cfg_valid && (|bus.cfg_target);
  assign pending = bus.node_req & target_reg & ~sent;

  // Round-robin search: first pending bit at or above ptr, wrapping past NODE_NUM-1.
  always_comb begin
    int j;
    j           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NODE_NUM; i++) begin
      j = int'(ptr) + i;
      if (j >= NODE_NUM) j = j - NODE_NUM;
      if (!grant_found && pending[ID_W'(j)]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(j);
      end
    end
  end

  assign ptr_nxt = (grant_idx == ID_W'(NODE_NUM - 1)) ? '0 : grant_idx + ID_W'(1);

  // A collector hit wins over any request in the same cycle.
  assign issue = (state == COLLECT) && bus.sync_gnt && grant_found && !bus.sync_hit;

`ifdef SYNC_TIMEOUT_EN
  logic [15:0] idle_cnt;
  logic        timeout_err_q;

  assign timeout_fire = (state == COLLECT) && !bus.sync_hit && !issue &&
                        (idle_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state == INIT || issue) begin
        idle_cnt <= '0;
      end else if (state == COLLECT) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
      if (accept) begin
        timeout_err_q <= 1'b0;
      end else if (timeout_fire) begin
        timeout_err_q <= 1'b1;
      end
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_fire    = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign to_release = (state == COLLECT) && (bus.sync_hit || timeout_fire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = INIT;
      INIT:    state_nxt = COLLECT;
      COLLECT: if (to_release) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready_c = (state == IDLE);
    busy_c      = (state != IDLE);
    sync_init_c = (state == INIT);
    sync_req_c  = issue;
    node_id_c   = issue ? grant_idx : last_id;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target_reg <= '0;
      sent       <= '0;
      ptr        <= '0;
      last_id    <= '0;
      release_q  <= '0;
    end else begin
      if (accept) begin
        target_reg <= bus.cfg_target;
        sent       <= '0;
      end else if (state == RELEASE) begin
        sent <= '0;
      end else if (issue) begin
        sent[grant_idx] <= 1'b1;
      end
      if (issue) begin
        ptr     <= ptr_nxt;
        last_id <= grant_idx;
      end
      // Registered so the release lands one cycle after the hit, during RELEASE.
      release_q <= to_release ? target_reg : '0;
    end
  end

  assign bus.cfg_ready    = cfg_ready_c;
  assign bus.busy         = busy_c;
  assign bus.sync_init    = sync_init_c;
  assign bus.sync_req     = sync_req_c;
  assign bus.sync_node_id = node_id_c;
  assign bus.sync_target  = target_reg;
  assign bus.node_release = release_q;

endmodule
